// File: rtl/ysyx_25040111_arbiter_pkg.sv
// Shared constants for the IFU/LSU AXI4 bus arbiter: owner-state encodings
// (also used by debug/difftest code) and fixed AXI field widths.
package ysyx_25040111_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_IFU_RD = 2'd1;
  localparam logic [1:0] ARB_LSU_RD = 2'd2;
  localparam logic [1:0] ARB_LSU_WR = 2'd3;

  localparam int ID_W    = 4;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

endpackage

// File: rtl/ysyx_25040111_arbiter.sv
// AXI4 master-side arbiter: grants io_master to the IFU or the LSU, one whole
// transaction at a time, with a registered owner FSM and combinational channel muxing.
module ysyx_25040111_arbiter
  import ysyx_25040111_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // IFU read channels
  input  logic                 ifu_arvalid,
  input  logic [ADDR_W-1:0]    ifu_araddr,
  input  logic [ID_W-1:0]      ifu_arid,
  input  logic [LEN_W-1:0]     ifu_arlen,
  input  logic [SIZE_W-1:0]    ifu_arsize,
  input  logic [BURST_W-1:0]   ifu_arburst,
  output logic                 ifu_arready,
  output logic                 ifu_rvalid,
  output logic [RESP_W-1:0]    ifu_rresp,
  output logic [DATA_W-1:0]    ifu_rdata,
  output logic                 ifu_rlast,
  output logic [ID_W-1:0]      ifu_rid,
  input  logic                 ifu_rready,
  // LSU read channels
  input  logic                 lsu_arvalid,
  input  logic [ADDR_W-1:0]    lsu_araddr,
  input  logic [ID_W-1:0]      lsu_arid,
  input  logic [LEN_W-1:0]     lsu_arlen,
  input  logic [SIZE_W-1:0]    lsu_arsize,
  input  logic [BURST_W-1:0]   lsu_arburst,
  output logic                 lsu_arready,
  output logic                 lsu_rvalid,
  output logic [RESP_W-1:0]    lsu_rresp,
  output logic [DATA_W-1:0]    lsu_rdata,
  output logic                 lsu_rlast,
  output logic [ID_W-1:0]      lsu_rid,
  input  logic                 lsu_rready,
  // LSU write channels
  input  logic                 lsu_awvalid,
  input  logic [ADDR_W-1:0]    lsu_awaddr,
  input  logic [ID_W-1:0]      lsu_awid,
  input  logic [LEN_W-1:0]     lsu_awlen,
  input  logic [SIZE_W-1:0]    lsu_awsize,
  input  logic [BURST_W-1:0]   lsu_awburst,
  output logic                 lsu_awready,
  input  logic                 lsu_wvalid,
  input  logic [DATA_W-1:0]    lsu_wdata,
  input  logic [DATA_W/8-1:0]  lsu_wstrb,
  input  logic                 lsu_wlast,
  output logic                 lsu_wready,
  output logic                 lsu_bvalid,
  output logic [RESP_W-1:0]    lsu_bresp,
  output logic [ID_W-1:0]      lsu_bid,
  input  logic                 lsu_bready,
  // io_master AXI4 port
  input  logic                 io_master_awready,
  output logic                 io_master_awvalid,
  output logic [ADDR_W-1:0]    io_master_awaddr,
  output logic [ID_W-1:0]      io_master_awid,
  output logic [LEN_W-1:0]     io_master_awlen,
  output logic [SIZE_W-1:0]    io_master_awsize,
  output logic [BURST_W-1:0]   io_master_awburst,
  input  logic                 io_master_wready,
  output logic                 io_master_wvalid,
  output logic [DATA_W-1:0]    io_master_wdata,
  output logic [DATA_W/8-1:0]  io_master_wstrb,
  output logic                 io_master_wlast,
  output logic                 io_master_bready,
  input  logic                 io_master_bvalid,
  input  logic [RESP_W-1:0]    io_master_bresp,
  input  logic [ID_W-1:0]      io_master_bid,
  input  logic                 io_master_arready,
  output logic                 io_master_arvalid,
  output logic [ADDR_W-1:0]    io_master_araddr,
  output logic [ID_W-1:0]      io_master_arid,
  output logic [LEN_W-1:0]     io_master_arlen,
  output logic [SIZE_W-1:0]    io_master_arsize,
  output logic [BURST_W-1:0]   io_master_arburst,
  output logic                 io_master_rready,
  input  logic                 io_master_rvalid,
  input  logic [RESP_W-1:0]    io_master_rresp,
  input  logic [DATA_W-1:0]    io_master_rdata,
  input  logic                 io_master_rlast,
  input  logic [ID_W-1:0]      io_master_rid
);

  logic [1:0] state;
  logic [1:0] state_nxt;

  // Priority LSU write > LSU read > IFU read; grant held until the last R beat or the B handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (lsu_awvalid)      state_nxt = ARB_LSU_WR;
        else if (lsu_arvalid) state_nxt = ARB_LSU_RD;
        else if (ifu_arvalid) state_nxt = ARB_IFU_RD;
      end
      ARB_IFU_RD, ARB_LSU_RD: begin
        if (io_master_rvalid && io_master_rready && io_master_rlast) state_nxt = ARB_IDLE;
      end
      ARB_LSU_WR: begin
        if (io_master_bvalid && io_master_bready) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // Unowned channels drive zero so the bus never carries X.
  always_comb begin
    ifu_arready       = 1'b0;
    ifu_rvalid        = 1'b0;
    ifu_rresp         = '0;
    ifu_rdata         = '0;
    ifu_rlast         = 1'b0;
    ifu_rid           = '0;
    lsu_arready       = 1'b0;
    lsu_rvalid        = 1'b0;
    lsu_rresp         = '0;
    lsu_rdata         = '0;
    lsu_rlast         = 1'b0;
    lsu_rid           = '0;
    lsu_awready       = 1'b0;
    lsu_wready        = 1'b0;
    lsu_bvalid        = 1'b0;
    lsu_bresp         = '0;
    lsu_bid           = '0;
    io_master_awvalid = 1'b0;
    io_master_awaddr  = '0;
    io_master_awid    = '0;
    io_master_awlen   = '0;
    io_master_awsize  = '0;
    io_master_awburst = '0;
    io_master_wvalid  = 1'b0;
    io_master_wdata   = '0;
    io_master_wstrb   = '0;
    io_master_wlast   = 1'b0;
    io_master_bready  = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_araddr  = '0;
    io_master_arid    = '0;
    io_master_arlen   = '0;
    io_master_arsize  = '0;
    io_master_arburst = '0;
    io_master_rready  = 1'b0;
    case (state)
      ARB_IFU_RD: begin
        io_master_arvalid = ifu_arvalid;
        io_master_araddr  = ifu_araddr;
        io_master_arid    = ifu_arid;
        io_master_arlen   = ifu_arlen;
        io_master_arsize  = ifu_arsize;
        io_master_arburst = ifu_arburst;
        ifu_arready       = io_master_arready;
        ifu_rvalid        = io_master_rvalid;
        ifu_rresp         = io_master_rresp;
        ifu_rdata         = io_master_rdata;
        ifu_rlast         = io_master_rlast;
        ifu_rid           = io_master_rid;
        io_master_rready  = ifu_rready;
      end
      ARB_LSU_RD: begin
        io_master_arvalid = lsu_arvalid;
        io_master_araddr  = lsu_araddr;
        io_master_arid    = lsu_arid;
        io_master_arlen   = lsu_arlen;
        io_master_arsize  = lsu_arsize;
        io_master_arburst = lsu_arburst;
        lsu_arready       = io_master_arready;
        lsu_rvalid        = io_master_rvalid;
        lsu_rresp         = io_master_rresp;
        lsu_rdata         = io_master_rdata;
        lsu_rlast         = io_master_rlast;
        lsu_rid           = io_master_rid;
        io_master_rready  = lsu_rready;
      end
      ARB_LSU_WR: begin
        io_master_awvalid = lsu_awvalid;
        io_master_awaddr  = lsu_awaddr;
        io_master_awid    = lsu_awid;
        io_master_awlen   = lsu_awlen;
        io_master_awsize  = lsu_awsize;
        io_master_awburst = lsu_awburst;
        lsu_awready       = io_master_awready;
        io_master_wvalid  = lsu_wvalid;
        io_master_wdata   = lsu_wdata;
        io_master_wstrb   = lsu_wstrb;
        io_master_wlast   = lsu_wlast;
        lsu_wready        = io_master_wready;
        lsu_bvalid        = io_master_bvalid;
        lsu_bresp         = io_master_bresp;
        lsu_bid           = io_master_bid;
        io_master_bready  = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040111_arbiter.sv
// Directed testbench for ysyx_25040111_arbiter: the bench plays both masters and the
// slave, and compares outputs against hand-computed values between clock edges.
module tb_ysyx_25040111_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_arvalid = 0, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready = 0;
  logic [31:0] ifu_araddr = 0, ifu_rdata;
  logic [3:0]  ifu_arid = 0, ifu_rid;
  logic [7:0]  ifu_arlen = 0;
  logic [2:0]  ifu_arsize = 0;
  logic [1:0]  ifu_arburst = 0, ifu_rresp;
  logic        lsu_arvalid = 0, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready = 0;
  logic [31:0] lsu_araddr = 0, lsu_rdata;
  logic [3:0]  lsu_arid = 0, lsu_rid;
  logic [7:0]  lsu_arlen = 0;
  logic [2:0]  lsu_arsize = 0;
  logic [1:0]  lsu_arburst = 0, lsu_rresp;
  logic        lsu_awvalid = 0, lsu_awready, lsu_wvalid = 0, lsu_wlast = 0, lsu_wready;
  logic [31:0] lsu_awaddr = 0, lsu_wdata = 0;
  logic [3:0]  lsu_awid = 0, lsu_wstrb = 0, lsu_bid;
  logic [7:0]  lsu_awlen = 0;
  logic [2:0]  lsu_awsize = 0;
  logic [1:0]  lsu_awburst = 0, lsu_bresp;
  logic        lsu_bvalid, lsu_bready = 0;
  logic        m_awready = 0, m_awvalid, m_wready = 0, m_wvalid, m_wlast, m_bready, m_bvalid = 0;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata = 0;
  logic [3:0]  m_awid, m_wstrb, m_bid = 0, m_arid, m_rid = 0;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_bresp = 0, m_arburst, m_rresp = 0;
  logic        m_arready = 0, m_arvalid, m_rready, m_rvalid = 0, m_rlast = 0;

  int n_chk = 0;
  int n_err = 0;

  ysyx_25040111_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen),
    .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata), .ifu_rlast(ifu_rlast),
    .ifu_rid(ifu_rid), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen),
    .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rresp(lsu_rresp), .lsu_rdata(lsu_rdata), .lsu_rlast(lsu_rlast),
    .lsu_rid(lsu_rid), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid), .lsu_awlen(lsu_awlen),
    .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
    .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
    .lsu_bready(lsu_bready),
    .io_master_awready(m_awready), .io_master_awvalid(m_awvalid), .io_master_awaddr(m_awaddr),
    .io_master_awid(m_awid), .io_master_awlen(m_awlen), .io_master_awsize(m_awsize),
    .io_master_awburst(m_awburst), .io_master_wready(m_wready), .io_master_wvalid(m_wvalid),
    .io_master_wdata(m_wdata), .io_master_wstrb(m_wstrb), .io_master_wlast(m_wlast),
    .io_master_bready(m_bready), .io_master_bvalid(m_bvalid), .io_master_bresp(m_bresp),
    .io_master_bid(m_bid), .io_master_arready(m_arready), .io_master_arvalid(m_arvalid),
    .io_master_araddr(m_araddr), .io_master_arid(m_arid), .io_master_arlen(m_arlen),
    .io_master_arsize(m_arsize), .io_master_arburst(m_arburst), .io_master_rready(m_rready),
    .io_master_rvalid(m_rvalid), .io_master_rresp(m_rresp), .io_master_rdata(m_rdata),
    .io_master_rlast(m_rlast), .io_master_rid(m_rid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with requests already pending: everything must stay quiet.
    lsu_awvalid = 1; m_awready = 1; m_arready = 1; m_wready = 1;
    #2;
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_awready", lsu_awready, 0);
    chk("rst_rready",  m_rready, 0);
    chk("rst_awaddr",  m_awaddr, 0);
    lsu_awvalid = 0;
    #10 rst_n = 1;
    step();

    // Single IFU read
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0000; ifu_arid = 4'h2;
    #1 chk("t1_idle_arvalid", m_arvalid, 0);
    step();
    chk("t1_arvalid", m_arvalid, 1);
    chk("t1_araddr", m_araddr, 32'h3000_0000);
    chk("t1_arid", m_arid, 4'h2);
    chk("t1_arready", ifu_arready, 1);
    step();
    ifu_arvalid = 0; ifu_araddr = 0;
    m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rlast = 1; ifu_rready = 1;
    #1;
    chk("t1_rvalid", ifu_rvalid, 1);
    chk("t1_rdata", ifu_rdata, 32'hDEAD_BEEF);
    chk("t1_rready", m_rready, 1);
    chk("t1_lsu_rvalid", lsu_rvalid, 0);
    step();
    m_rvalid = 0; m_rlast = 0;
    #1 chk("t1_idle_rready", m_rready, 0);

    // Simultaneous IFU and LSU reads: LSU first
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0040;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0000;
    step();
    chk("t2_lsu_first", m_araddr, 32'h8000_0000);
    chk("t2_ifu_arready", ifu_arready, 0);
    chk("t2_lsu_arready", lsu_arready, 1);
    step();
    lsu_arvalid = 0; lsu_araddr = 0;
    m_rvalid = 1; m_rlast = 1; m_rdata = 32'h0000_0011; lsu_rready = 1;
    #1;
    chk("t2_ifu_arready_hold", ifu_arready, 0);
    chk("t2_lsu_rdata", lsu_rdata, 32'h11);
    chk("t2_ifu_rvalid", ifu_rvalid, 0);
    step();
    m_rvalid = 0; m_rlast = 0;
    #1 chk("t2_release_idle", m_arvalid, 0);
    step();
    chk("t2_ifu_granted", m_arvalid, 1);
    chk("t2_ifu_addr", m_araddr, 32'h3000_0040);
    step();
    ifu_arvalid = 0; m_rvalid = 1; m_rlast = 1;
    step();
    m_rvalid = 0; m_rlast = 0; lsu_rready = 0;

    // LSU store, W accepted 3 cycles before AW
    m_awready = 0; m_wready = 1;
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0004; lsu_awid = 4'h5;
    lsu_wvalid = 1; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b1111; lsu_wlast = 1;
    step();
    m_rvalid = 1;
    #1;
    chk("t3_awaddr", m_awaddr, 32'h8000_0004);
    chk("t3_wdata", m_wdata, 32'h1234_5678);
    chk("t3_wstrb", m_wstrb, 4'b1111);
    chk("t3_wready", lsu_wready, 1);
    chk("t3_awready_low", lsu_awready, 0);
    chk("t3_no_ifu_r", ifu_rvalid, 0);
    chk("t3_no_rready", m_rready, 0);
    step();
    lsu_wvalid = 0; lsu_wdata = 0; lsu_wlast = 0;
    step();
    step();
    m_awready = 1;
    #1 chk("t3_awready", lsu_awready, 1);
    chk("t3_awvalid", m_awvalid, 1);
    step();
    lsu_awvalid = 0; m_awready = 0;
    m_bvalid = 1; m_bid = 4'h5; m_bresp = 2'b00; lsu_bready = 1;
    #1;
    chk("t3_bvalid", lsu_bvalid, 1);
    chk("t3_bid", lsu_bid, 4'h5);
    chk("t3_bready", m_bready, 1);
    chk("t3_no_ifu_r2", ifu_rvalid, 0);
    step();
    m_bvalid = 0; m_rvalid = 0;
    #1 chk("t3_idle_bready", m_bready, 0);

    // IFU 4-beat burst with LSU request raised mid-burst
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0100; ifu_arlen = 8'd3; ifu_rready = 1;
    step();
    chk("t4_arlen", m_arlen, 8'd3);
    step();
    ifu_arvalid = 0; ifu_arlen = 0;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1; m_rlast = (b == 3); m_rdata = 32'(b) + 32'hA0;
      if (b == 1) begin
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0010;
      end
      #1;
      chk("t4_beat_valid", ifu_rvalid, 1);
      chk("t4_beat_data", ifu_rdata, 32'(b) + 32'hA0);
      chk("t4_lsu_blocked", lsu_arready, 0);
      step();
    end
    m_rvalid = 0; m_rlast = 0;
    #1 chk("t4_idle_after_rlast", m_arvalid, 0);
    step();
    chk("t4_lsu_granted", m_araddr, 32'h8000_0010);
    chk("t4_lsu_arready", lsu_arready, 1);
    step();

    // Error response forwarded to LSU
    lsu_arvalid = 0; lsu_araddr = 0;
    m_rvalid = 1; m_rlast = 1; m_rresp = 2'b10; lsu_rready = 1;
    #1;
    chk("t5_rresp", lsu_rresp, 2'b10);
    chk("t5_rvalid", lsu_rvalid, 1);
    step();
    m_rvalid = 0; m_rlast = 0; m_rresp = 0;
    #1 chk("t5_idle", m_rready, 0);

    // Reset asserted mid-LSU_WR, before B
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0020; lsu_wvalid = 1;
    step();
    chk("t6_awvalid", m_awvalid, 1);
    m_bvalid = 1;
    #2 rst_n = 0;
    #1;
    chk("t6_rst_awvalid", m_awvalid, 0);
    chk("t6_rst_wvalid", m_wvalid, 0);
    chk("t6_rst_bvalid", lsu_bvalid, 0);
    chk("t6_rst_bready", m_bready, 0);
    lsu_awvalid = 0; lsu_wvalid = 0; m_bvalid = 0;
    #1 rst_n = 1;
    step();
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0200;
    #1 chk("t6_idle", m_arvalid, 0);
    step();
    chk("t6_ifu_granted", m_arvalid, 1);
    chk("t6_ifu_addr", m_araddr, 32'h3000_0200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
